// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Sequencing controller for the instruction-fetch stage. It arbitrates between
// branch redirects from EX, load-use hazards from decode, instruction-memory
// wait states and halt/resume requests. It drives the fetch stage's stall,
// pc_src and branch_target inputs, the pipeline flush strobes, a sticky memory
// timeout error and a saturating stall-cycle counter.
//
// Parameters:
//   MEM_TIMEOUT  max consecutive MEM_WAIT cycles before a timeout error (>=1)
//   CNT_W        width of the stall-cycle counter
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset; forces every output to 0
//   imem_ready     instruction memory returned valid data this cycle
//   hazard_stall   load-use hazard from decode
//   br_taken       branch/jump resolved taken in EX
//   br_target      resolved target address, valid with br_taken
//   halt_req       ecall/ebreak halt request
//   resume         leave HALTED (only when no memory error is pending)
//   stall          to instruction_fetch.stall
//   pc_src         to instruction_fetch.pc_src
//   branch_target  to instruction_fetch.branch_target (captured target)
//   flush_if_id    bubble the IF/ID register
//   flush_id_ex    bubble the ID/EX register
//   halted         controller is in HALTED
//   mem_err        sticky instruction-memory timeout
//   stall_count    saturating count of cycles with stall=1
// -----------------------------------------------------------------------------
module fetch_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic             hazard_stall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             halt_req,
  input  logic             resume,
  output logic             stall,
  output logic             pc_src,
  output logic [31:0]      branch_target,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);

  // Wide enough to hold the value MEM_TIMEOUT itself.
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2,
    HALTED   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       tgt_q, tgt_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_count_q;

  // Ungated outputs; the port versions are forced low while rst is high.
  logic stall_raw, pc_src_raw, flush_if_id_raw, flush_id_ex_raw, halted_raw;

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d         = state_q;
    tgt_d           = tgt_q;
    wait_cnt_d      = wait_cnt_q;
    mem_err_d       = mem_err_q;
    stall_raw       = 1'b0;
    pc_src_raw      = 1'b0;
    flush_if_id_raw = 1'b0;
    flush_id_ex_raw = 1'b0;
    halted_raw      = 1'b0;

    unique case (state_q)
      RUN: begin
        stall_raw       = hazard_stall | ~imem_ready;
        // A taken branch squashes the hazard bubble: the redirect flushes anyway.
        flush_id_ex_raw = hazard_stall & ~br_taken;
        if (br_taken) begin
          tgt_d   = br_target;
          state_d = REDIRECT;
        end else if (halt_req) begin
          state_d = HALTED;
        end else if (!imem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end

      MEM_WAIT: begin
        stall_raw = 1'b1;
        if (br_taken) begin
          // The outstanding fetch is on the wrong path; drop it.
          tgt_d      = br_target;
          state_d    = REDIRECT;
          wait_cnt_d = '0;
        end else if (imem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
          state_d    = HALTED;
          mem_err_d  = 1'b1;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end

      REDIRECT: begin
        // Single-cycle state; any br_taken now comes from a flushed instruction.
        pc_src_raw      = 1'b1;
        flush_if_id_raw = 1'b1;
        flush_id_ex_raw = 1'b1;
        state_d         = RUN;
      end

      HALTED: begin
        stall_raw  = 1'b1;
        halted_raw = 1'b1;
        // A memory timeout can only be cleared by reset.
        if (resume && !mem_err_q) begin
          state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output gating: everything reads as 0 while reset is asserted.
  // ---------------------------------------------------------------------------
  assign stall         = ~rst & stall_raw;
  assign pc_src        = ~rst & pc_src_raw;
  assign flush_if_id   = ~rst & flush_if_id_raw;
  assign flush_id_ex   = ~rst & flush_id_ex_raw;
  assign halted        = ~rst & halted_raw;
  assign mem_err       = ~rst & mem_err_q;
  assign branch_target = rst ? 32'd0 : tgt_q;
  assign stall_count   = rst ? '0 : stall_count_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q       <= RUN;
      tgt_q         <= 32'd0;
      wait_cnt_q    <= '0;
      mem_err_q     <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      if (stall && !(&stall_count_q)) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
    end
  end

endmodule
